// File: rtl/sys_defs.sv
// sys_defs: shared ROB exit packet, retirement FSM states and stop causes.
// N and PHYS_REG_SZ fall back to defaults when not supplied by the build.
`default_nettype none

`ifndef N
`define N 3
`endif
`ifndef PHYS_REG_SZ
`define PHYS_REG_SZ 64
`endif

package sys_defs;

  localparam int PHYS_REG_SZ_DEF = `PHYS_REG_SZ;
  localparam int ARCH_REG_SZ_DEF = 32;
  localparam int PR_BITS         = $clog2(PHYS_REG_SZ_DEF);
  localparam int AR_BITS         = $clog2(ARCH_REG_SZ_DEF);

  typedef struct packed {
    logic [PR_BITS-1:0] T_new;
    logic [PR_BITS-1:0] T_old;
    logic [AR_BITS-1:0] Tarch;
    logic               has_dest;
    logic               complete;
    logic               mispredict;
    logic               halt;
  } ROB_EXIT_PACKET;

  typedef enum logic [1:0] {
    RS_RUN     = 2'd0,
    RS_RECOVER = 2'd1,
    RS_HALTED  = 2'd2
  } RETIRE_STATE;

  typedef enum logic [1:0] {
    STOP_NONE       = 2'd0,
    STOP_MISPREDICT = 2'd1,
    STOP_HALT       = 2'd2
  } STOP_CAUSE;

endpackage

`default_nettype wire

// File: rtl/retire_select.sv
// retire_select: in-order prefix scan of the ROB head; yields the retire mask,
// the retire count and why the scan stopped early (mispredict/halt).
`default_nettype none

module retire_select
  import sys_defs::*;
#(
  parameter int N               = `N,
  localparam int NUM_SCALAR_BITS = $clog2(N+1)
) (
  input  logic                       enable,
  input  logic [N-1:0]               complete,
  input  logic [N-1:0]               mispredict,
  input  logic [N-1:0]               halt,
  input  logic [NUM_SCALAR_BITS-1:0] outputs_valid,
  output logic [N-1:0]               retire_mask,
  output logic [NUM_SCALAR_BITS-1:0] num_retiring,
  output STOP_CAUSE                  stop_cause
);

  logic blocked;

  always_comb begin
    retire_mask  = '0;
    num_retiring = '0;
    stop_cause   = STOP_NONE;
    blocked      = !enable;
    for (int i = 0; i < N; i++) begin
      if (!blocked && (i < int'(outputs_valid)) && complete[i]) begin
        retire_mask[i] = 1'b1;
        num_retiring   = num_retiring + NUM_SCALAR_BITS'(1);
        // Halt outranks mispredict on the same slot: no flush after a halt.
        if (halt[i]) begin
          stop_cause = STOP_HALT;
          blocked    = 1'b1;
        end else if (mispredict[i]) begin
          stop_cause = STOP_MISPREDICT;
          blocked    = 1'b1;
        end
      end else begin
        blocked = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/retire_ctrl.sv
// retire_ctrl: N-wide in-order retirement with flush sequencing and halt freeze.
// Optional RETIRE_PERF_EN adds saturating retired/stall performance counters.
`default_nettype none

module retire_ctrl
  import sys_defs::*;
#(
  parameter int N              = `N,
  parameter int PHYS_REG_SZ    = `PHYS_REG_SZ,
  parameter int ARCH_REG_SZ    = 32,
  parameter int RECOVER_CYCLES = 2,
  parameter int CNT_W          = 32,
  localparam int PR_BITS         = $clog2(PHYS_REG_SZ),
  localparam int AR_BITS         = $clog2(ARCH_REG_SZ),
  localparam int NUM_SCALAR_BITS = $clog2(N+1)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  ROB_EXIT_PACKET [N-1:0]          rob_outputs,
  input  logic [NUM_SCALAR_BITS-1:0]      outputs_valid,
  output logic [NUM_SCALAR_BITS-1:0]      num_retiring,
  output logic [N-1:0]                    free_valid,
  output logic [N-1:0][PR_BITS-1:0]       free_reg,
  output logic [N-1:0]                    amt_wr_en,
  output logic [N-1:0][AR_BITS-1:0]       amt_wr_arch,
  output logic [N-1:0][PR_BITS-1:0]       amt_wr_phys,
  output logic                            flush,
  output logic                            recover_busy,
`ifdef RETIRE_PERF_EN
  output logic [CNT_W-1:0]                retired_count,
  output logic [CNT_W-1:0]                stall_cycles,
`endif
  output logic                            halted
);

  RETIRE_STATE state_q, state_d;
  logic [3:0]  rec_cnt_q, rec_cnt_d;
  logic        flush_q, flush_d;

  logic [N-1:0] complete, mispredict, halt, retire_mask;
  STOP_CAUSE    stop_cause;
  logic         scan_en;

  assign scan_en = (state_q == RS_RUN) && !reset;

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign complete[i]   = rob_outputs[i].complete;
    assign mispredict[i] = rob_outputs[i].mispredict;
    assign halt[i]       = rob_outputs[i].halt;
  end

  retire_select #(.N(N)) u_select (
    .enable        (scan_en),
    .complete      (complete),
    .mispredict    (mispredict),
    .halt          (halt),
    .outputs_valid (outputs_valid),
    .retire_mask   (retire_mask),
    .num_retiring  (num_retiring),
    .stop_cause    (stop_cause)
  );

  for (genvar i = 0; i < N; i++) begin : g_slot
    logic wr;
    assign wr             = retire_mask[i] && rob_outputs[i].has_dest;
    assign amt_wr_en[i]   = wr;
    assign free_valid[i]  = wr;
    assign amt_wr_arch[i] = wr ? AR_BITS'(rob_outputs[i].Tarch) : '0;
    assign amt_wr_phys[i] = wr ? PR_BITS'(rob_outputs[i].T_new) : '0;
    assign free_reg[i]    = wr ? PR_BITS'(rob_outputs[i].T_old) : '0;
  end

  always_comb begin
    state_d   = state_q;
    rec_cnt_d = rec_cnt_q;
    flush_d   = 1'b0;
    case (state_q)
      RS_RUN: begin
        if (stop_cause == STOP_MISPREDICT) begin
          state_d   = RS_RECOVER;
          rec_cnt_d = 4'(RECOVER_CYCLES - 1);
          flush_d   = 1'b1;
        end else if (stop_cause == STOP_HALT) begin
          state_d = RS_HALTED;
        end
      end
      RS_RECOVER: begin
        if (rec_cnt_q == 4'd0) begin
          state_d = RS_RUN;
        end else begin
          rec_cnt_d = rec_cnt_q - 4'd1;
        end
      end
      RS_HALTED: state_d = RS_HALTED;
      default:   state_d = RS_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RS_RUN;
      rec_cnt_q <= 4'd0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rec_cnt_q <= rec_cnt_d;
      flush_q   <= flush_d;
    end
  end

  assign flush        = flush_q;
  assign recover_busy = (state_q == RS_RECOVER);
  assign halted       = (state_q == RS_HALTED);

`ifdef RETIRE_PERF_EN
  logic [CNT_W-1:0] retired_count_q, retired_count_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W:0]   retired_sum;

  always_comb begin
    retired_sum     = {1'b0, retired_count_q} + (CNT_W+1)'(num_retiring);
    retired_count_d = retired_sum[CNT_W] ? '1 : retired_sum[CNT_W-1:0];
    stall_cycles_d  = stall_cycles_q;
    if ((state_q == RS_RUN) && (outputs_valid != '0) && (num_retiring == '0)
        && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      retired_count_q <= '0;
      stall_cycles_q  <= '0;
    end else begin
      retired_count_q <= retired_count_d;
      stall_cycles_q  <= stall_cycles_d;
    end
  end

  assign retired_count = retired_count_q;
  assign stall_cycles  = stall_cycles_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_retire_ctrl.sv
// tb_retire_ctrl: scoreboard bench for retire_ctrl with N=3, RECOVER_CYCLES=2.
`default_nettype none

module tb_retire_ctrl;
  import sys_defs::*;

  localparam int N  = 3;
  localparam int PR = PR_BITS;
  localparam int AR = AR_BITS;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  ROB_EXIT_PACKET [N-1:0] rob_outputs = '0;
  logic [1:0]             outputs_valid = '0;
  logic [1:0]             num_retiring;
  logic [N-1:0]           free_valid, amt_wr_en;
  logic [N-1:0][PR-1:0]   free_reg, amt_wr_phys;
  logic [N-1:0][AR-1:0]   amt_wr_arch;
  logic                   flush, recover_busy, halted;
`ifdef RETIRE_PERF_EN
  logic [31:0]            retired_count, stall_cycles;
`endif

  always #5 clock = ~clock;

  retire_ctrl #(.N(N), .PHYS_REG_SZ(`PHYS_REG_SZ), .ARCH_REG_SZ(32),
                .RECOVER_CYCLES(2), .CNT_W(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .rob_outputs   (rob_outputs),
    .outputs_valid (outputs_valid),
    .num_retiring  (num_retiring),
    .free_valid    (free_valid),
    .free_reg      (free_reg),
    .amt_wr_en     (amt_wr_en),
    .amt_wr_arch   (amt_wr_arch),
    .amt_wr_phys   (amt_wr_phys),
    .flush         (flush),
    .recover_busy  (recover_busy),
`ifdef RETIRE_PERF_EN
    .retired_count (retired_count),
    .stall_cycles  (stall_cycles),
`endif
    .halted        (halted)
  );

  typedef struct {
    ROB_EXIT_PACKET [N-1:0] pk;
    int  num;
    bit  fl, bz, ht, cp;
    int  rc, sc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic ROB_EXIT_PACKET mk(input int tn, input int to, input int ta,
                                        input bit hd, input bit c, input bit m, input bit h);
    ROB_EXIT_PACKET p;
    p.T_new = PR'(tn); p.T_old = PR'(to); p.Tarch = AR'(ta);
    p.has_dest = hd; p.complete = c; p.mispredict = m; p.halt = h;
    return p;
  endfunction

  // One cycle: drive at negedge, record expectation, compare 2ns later.
  task automatic step(input ROB_EXIT_PACKET [N-1:0] p, input int v, input bit rst,
                      input int num, input bit fl, input bit bz, input bit ht,
                      input bit cp, input int rc, input int sc, input string tag);
    exp_t e;
    logic [N-1:0]         e_en;
    logic [N-1:0][PR-1:0] e_free, e_phys;
    logic [N-1:0][AR-1:0] e_arch;
    @(negedge clock);
    rob_outputs   = p;
    outputs_valid = 2'(v);
    reset         = rst;
    e.pk = p; e.num = num; e.fl = fl; e.bz = bz; e.ht = ht;
    e.cp = cp; e.rc = rc; e.sc = sc;
    exp_q.push_back(e);
    #2;
    e = exp_q.pop_front();
    e_en = '0; e_free = '0; e_phys = '0; e_arch = '0;
    for (int i = 0; i < N; i++) begin
      if (i < e.num && e.pk[i].has_dest) begin
        e_en[i]   = 1'b1;
        e_free[i] = e.pk[i].T_old;
        e_phys[i] = e.pk[i].T_new;
        e_arch[i] = e.pk[i].Tarch;
      end
    end
    check({tag, ".num"},   64'(num_retiring), 64'(e.num));
    check({tag, ".flush"}, 64'(flush),        64'(e.fl));
    check({tag, ".busy"},  64'(recover_busy), 64'(e.bz));
    check({tag, ".halt"},  64'(halted),       64'(e.ht));
    check({tag, ".amt_en"},  64'(amt_wr_en),   64'(e_en));
    check({tag, ".free_v"},  64'(free_valid),  64'(e_en));
    check({tag, ".free_reg"},64'(free_reg),    64'(e_free));
    check({tag, ".amt_arch"},64'(amt_wr_arch), 64'(e_arch));
    check({tag, ".amt_phys"},64'(amt_wr_phys), 64'(e_phys));
`ifdef RETIRE_PERF_EN
    if (e.cp) begin
      check({tag, ".retired"}, 64'(retired_count), 64'(e.rc));
      check({tag, ".stalls"},  64'(stall_cycles),  64'(e.sc));
    end
`endif
  endtask

  ROB_EXIT_PACKET [N-1:0] full, gap, mixd, misp1, hm0, misp0, two, inc;

  initial begin
    full[0] = mk(10, 20, 1, 1, 1, 0, 0);
    full[1] = mk(11, 21, 2, 1, 1, 0, 0);
    full[2] = mk(12, 22, 3, 1, 1, 0, 0);
    gap  = full; gap[1].complete = 1'b0;
    mixd = full; mixd[1].has_dest = 1'b0;
    misp1 = full; misp1[1].mispredict = 1'b1;
    hm0 = full; hm0[0].mispredict = 1'b1; hm0[0].halt = 1'b1;
    misp0 = full; misp0[0].mispredict = 1'b1;
    two = full; two[0] = mk(30, 40, 7, 1, 1, 0, 0); two[1] = mk(31, 41, 8, 1, 1, 0, 0);
    inc = full; inc[0].complete = 1'b0;

    reset = 1'b1;
    repeat (2) @(posedge clock);

    //     pkts   v  rst num fl bz ht cp rc sc
    step(full,  3, 1, 0, 0, 0, 0, 0, 0, 0, "in_reset");
    step(full,  3, 0, 3, 0, 0, 0, 1, 0, 0, "full");
    step(gap,   3, 0, 1, 0, 0, 0, 0, 0, 0, "gap");
    step(full,  2, 0, 2, 0, 0, 0, 0, 0, 0, "valid2");
    step(full,  0, 0, 0, 0, 0, 0, 0, 0, 0, "valid0");
    step(mixd,  3, 0, 3, 0, 0, 0, 0, 0, 0, "no_dest");
    step(misp1, 3, 0, 2, 0, 0, 0, 0, 0, 0, "misp_c0");
    step(full,  3, 0, 0, 1, 1, 0, 0, 0, 0, "misp_c1");
    step(full,  3, 0, 0, 0, 1, 0, 0, 0, 0, "misp_c2");
    step(full,  3, 0, 3, 0, 0, 0, 0, 0, 0, "misp_c3");
    step(hm0,   3, 0, 1, 0, 0, 0, 0, 0, 0, "hm_c0");
    step(full,  3, 0, 0, 0, 0, 1, 0, 0, 0, "hm_c1");
    step(full,  3, 0, 0, 0, 0, 1, 0, 0, 0, "hm_c2");
    step(full,  3, 1, 0, 0, 0, 1, 0, 0, 0, "halt_rst");
    step(full,  3, 0, 3, 0, 0, 0, 0, 0, 0, "after_halt");
    step(misp0, 3, 0, 1, 0, 0, 0, 0, 0, 0, "rr_c0");
    step(full,  3, 1, 0, 1, 1, 0, 0, 0, 0, "rr_c1");
    step(full,  0, 0, 0, 0, 0, 0, 1, 0, 0, "rr_c2");
    for (int k = 0; k < 4; k++) step(two, 2, 0, 2, 0, 0, 0, 0, 0, 0, "perf_ret");
    for (int k = 0; k < 3; k++) step(inc, 1, 0, 0, 0, 0, 0, 0, 0, 0, "perf_stall");
    step(full,  0, 0, 0, 0, 0, 0, 1, 8, 3, "perf_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/retire_ctrl.md
# retire_ctrl

In-order N-wide retirement controller that sits directly on the ROB head. Each cycle it scans the oldest `outputs_valid` ROB entries and tells the ROB how many to clear via `num_retiring`. For each retired instruction it drives the architectural map table update and frees the old physical register. On a retired branch mispredict it sequences a multi-cycle pipeline flush, and on a retired halt it freezes retirement until reset.

## Interface
Parameters:
- `N`, default `` `N ``: superscalar width; number of head entries scanned per cycle.
- `PHYS_REG_SZ`, default `` `PHYS_REG_SZ ``: number of physical registers; `PR_BITS = $clog2(PHYS_REG_SZ)`.
- `ARCH_REG_SZ`, default 32: number of architectural registers; `AR_BITS = $clog2(ARCH_REG_SZ)`.
- `RECOVER_CYCLES`, default 2: total cycles spent in RECOVER; legal range 1..15.
- `CNT_W`, default 32: width of the performance counters.
- `NUM_SCALAR_BITS`, localparam: `$clog2(N+1)`.

Ports:
- `clock`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `rob_outputs`, in, `ROB_EXIT_PACKET [N-1:0]`: ROB head entries, index 0 is the oldest.
- `outputs_valid`, in, `NUM_SCALAR_BITS`: count of meaningful entries in `rob_outputs`; higher indices are ignored.
- `num_retiring`, out, `NUM_SCALAR_BITS`: number of entries the ROB clears this cycle.
- `free_valid`, out, `[N-1:0]`: per-slot push to the free list.
- `free_reg`, out, `[N-1:0][PR_BITS-1:0]`: the T_old being freed in each slot.
- `amt_wr_en`, out, `[N-1:0]`: per-slot architectural map write enable.
- `amt_wr_arch`, out, `[N-1:0][AR_BITS-1:0]`: architectural destination register.
- `amt_wr_phys`, out, `[N-1:0][PR_BITS-1:0]`: T_new written into the map.
- `flush`, out, 1: one-cycle pipeline squash pulse.
- `recover_busy`, out, 1: high while in RECOVER.
- `halted`, out, 1: high in HALTED.
- `retired_count`, out, `CNT_W`: only when `RETIRE_PERF_EN` is defined.
- `stall_cycles`, out, `CNT_W`: only when `RETIRE_PERF_EN` is defined.

## Operation
- FSM states: RUN, RECOVER, HALTED. Reset state is RUN.
- **RUN scan**:
  - Slot i retires iff all of the following hold: i < `outputs_valid`, every slot j<i retires, `rob_outputs[i].complete`, and no slot j<i carries `mispredict` or `halt`.
  - `num_retiring` is the count of retiring slots. It is a contiguous prefix of the head entries.
- **Per retiring slot i**:
  - If `has_dest`: `amt_wr_en[i]=1`, `amt_wr_arch[i]=Tarch`, `amt_wr_phys[i]=T_new`, `free_valid[i]=1`, `free_reg[i]=T_old`.
  - Otherwise all four outputs for that slot are 0.
  - Non-retiring slots drive 0 on every per-slot output.
- **Mispredict**: if a retiring slot has `mispredict` (and not `halt`), the slot itself retires and all younger slots are blocked. The next state is RECOVER.
- **Halt**: if a retiring slot has `halt`, the slot retires, younger slots are blocked, and the next state is HALTED. Halt wins over mispredict on the same slot, so no flush is issued.
- **RECOVER**:
  - `num_retiring=0`, all per-slot outputs are 0.
  - A 4-bit down-counter is loaded with `RECOVER_CYCLES-1` on entry. The FSM returns to RUN when the counter reaches 0.
- **HALTED**: `num_retiring=0` and all per-slot outputs are 0 until reset.
- **Invariants**:
  - `num_retiring <= outputs_valid` always.
  - `num_retiring == 0` whenever `reset`, RECOVER or HALTED holds.

## Timing
- `num_retiring`, `free_*` and `amt_*` are combinational from `rob_outputs`/`outputs_valid` in RUN, with zero latency. The ROB and free list consume them at the same posedge.
- `flush` is registered: it is high exactly for the first RECOVER cycle, i.e. the cycle after the mispredicting instruction retires.
- `recover_busy` is high for exactly `RECOVER_CYCLES` cycles.
- `halted` rises the cycle after the halt retires.
- Reset values: FSM=RUN; `flush`, `recover_busy`, `halted` = 0; all counters = 0. Combinational outputs are forced to 0 while `reset` is high.
- Reset mid-RECOVER or in HALTED returns the FSM to RUN on the next edge. A pending flush is dropped.

## Configuration
- **`RETIRE_PERF_EN` defined**:
  - `retired_count` adds `num_retiring` each cycle.
  - `stall_cycles` increments on any RUN cycle with `outputs_valid!=0 && num_retiring==0`.
  - Both counters saturate at all-ones.
- **Undefined**: both ports and both counters are absent. All other behaviour is identical.

## Structure
- **Shared package** (`sys_defs`): `ROB_EXIT_PACKET` (fields `T_new`, `T_old`, `Tarch`, `has_dest`, `complete`, `mispredict`, `halt`) and the `RETIRE_STATE` enum.
- **Sub-module** `retire_select`: the combinational prefix/priority scan producing the retire mask, `num_retiring` and the stop-cause (none/mispredict/halt).
- The FSM, recovery counter and perf counters stay in `retire_ctrl`.

## Test plan
- **Full retire**, N=3: 3 complete entries, none flagged -> `num_retiring=3`; `amt_wr_en=3'b111`; `free_reg` = the three T_old values.
- **Gap**: entry0 complete, entry1 incomplete, entry2 complete -> `num_retiring=1`; only slot 0 outputs are active.
- **Mispredict**: mispredict on entry1, all entries complete, `RECOVER_CYCLES=2`.
  - Cycle 0: `num_retiring=2`.
  - Cycle 1: `flush=1`, `recover_busy=1`.
  - Cycle 2: `flush=0`, `recover_busy=1`.
  - Cycle 3: RUN, retirement resumes.
- **Halt+mispredict**: halt and mispredict both on entry0 -> `num_retiring=1`; `flush` never asserted; `halted=1` the next cycle; further complete entries give `num_retiring=0`.
- **Reset in RECOVER**: assert reset during the first RECOVER cycle -> the next cycle is RUN; `flush`/`recover_busy` are 0; perf counters are 0.
- **Perf** (`RETIRE_PERF_EN`): 4 cycles retiring 2, then 3 stalled cycles -> `retired_count=8`, `stall_cycles=3`.
